testmasterslave5_arbiter: RTL
=============================

# testmasterslave5_arbiter

Two-requester round-robin arbiter that shares one blocking master output port between two blocking slave inputs. Each request is a 32-bit integer qualified by a `_sync` flag. The arbiter latches the winning word and presents it downstream with a notify/sync handshake until the sink accepts it. It sits in front of the TestMasterSlave5 datapath as the scheduler for its shared output resource.

## Interface
Parameters:
- `RESET_VAL`, default 1337: value driven on `m_out` from reset until the first grant.
- `CNT_W`, default 16: width of the per-requester saturating grant counters.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: reset, asynchronous and active-low. Asserting it (`rst`=0) resets immediately; deassertion is sampled on `clk`.
- `req0`, in, 32: requester 0 data.
- `req0_sync`, in, 1: requester 0 valid.
- `req0_notify`, out, 1: one-cycle pulse telling requester 0 its word was captured.
- `req1`, `req1_sync`, `req1_notify`: same as the three requester 0 ports, for requester 1.
- `m_out`, out, 32: data presented to the shared sink.
- `m_out_notify`, out, 1: `m_out` is valid.
- `m_out_sync`, in, 1: sink accepts `m_out` in this cycle.
- `grant_id`, out, 1: requester that owns the current or last transfer.
- `gnt_cnt0`, out, `CNT_W`: saturating count of grants to requester 0.
- `gnt_cnt1`, out, `CNT_W`: saturating count of grants to requester 1.

## Operation
- **States:** `section_idle` and `section_send`.
- **Reset values:**
  - `section` = `section_idle`, `m_out` = `RESET_VAL`.
  - `m_out_notify`, `req0_notify`, `req1_notify`, `gnt_cnt0`, `gnt_cnt1` = 0.
  - `grant_id` = 1, so requester 0 wins the first tie.
- **In `section_idle` with any `reqX_sync` high, pick a winner:**
  - Only one sync high: that requester wins.
  - Both high: the requester ≠ `grant_id` wins (round-robin).
- **On that grant:**
  - `m_out` ← winner data, `m_out_notify` ← 1.
  - `reqW_notify` ← 1, for exactly one cycle.
  - `grant_id` ← W.
  - `gnt_cntW` ← `gnt_cntW`+1, saturating at all-ones.
  - `section` ← `section_send`.
- **In `section_send`:**
  - `m_out` and `m_out_notify` are held stable; no requests are sampled.
  - When `m_out_sync`=1: `m_out_notify` ← 0 and `section` ← `section_idle`.
  - `m_out` keeps its last value after the transfer.
- **Idle with no requests:** all outputs hold; `reqX_notify` is 0.
- **Requester obligation:** after seeing `notify`, a requester deasserts `sync` or presents a new word. A `sync` still high in the next idle cycle is treated as a new request.
- **`m_out_sync` while idle:** ignored.
- **Reset mid-`section_send`:** aborts the transfer. The word is lost, every output returns to its reset value, and no notify is issued.

## Timing
- All outputs are registered.
- Request sampled in idle cycle N:
  - `m_out`, `m_out_notify`, `reqW_notify`, `grant_id` and the counters update, visible in cycle N+1.
  - `reqW_notify` drops in N+2.
- Sink handshake:
  - If `m_out_sync` is high in N+1, the transfer completes; `m_out_notify` is 0 in N+2 and the state is idle in N+2.
  - The next grant can become visible in N+3.
  - Peak throughput: one transfer per 2 cycles.
- Backpressure of k cycles extends `section_send` by k cycles.
- Losing requester: keeps `sync` high and wins the next idle cycle if the other requester is idle or was just served.

## Structure
- **Package `testmasterslave5_types`:**
  - Enum `TestMasterSlave5_arbiter_SECTIONS` {`section_idle`, `section_send`}.
  - Default constant for `RESET_VAL` (1337).
- **Sub-module `testmasterslave5_rr_pick`:** combinational. Inputs: two syncs and `grant_id`. Outputs: `any` and `winner`.
- The top module holds the state register, the data latch and the counters.

## Test plan
- **Reset:** hold `rst`=0 with activity on the inputs → `m_out`=1337, all notifies 0, counters 0, `grant_id`=1.
- **Single request:** `req0`=5 with sync for one cycle, `m_out_sync`=1 → next cycle `m_out`=5, `m_out_notify`=1, `req0_notify` pulse, `gnt_cnt0`=1; idle two cycles after the request.
- **Contention:** both syncs held, `req0`=10, `req1`=20, sink always ready → `m_out` sequence 10, 20, 10, 20; `grant_id` alternates 0, 1, 0, 1.
- **Backpressure:** `m_out_sync` low for 3 cycles after a grant → `m_out` and `m_out_notify` stable for 4 cycles; `req1_sync` raised meanwhile is not granted until idle.
- **Saturation:** `CNT_W`=2, six grants to requester 1 → `gnt_cnt1` stays at 3.
- **Reset mid-transfer:** assert `rst` during `section_send` → immediately `m_out_notify`=0 and `m_out`=1337; after release the state is idle and the counters are 0.

Source files
------------

// File: rtl/testmasterslave5_arbiter_pkg.sv
// Shared types for the TestMasterSlave5 output-port arbiter.
// Section encoding and the default value shown on m_out before the first grant.
package testmasterslave5_types;

  typedef enum logic {
    section_idle = 1'b0,
    section_send = 1'b1
  } TestMasterSlave5_arbiter_SECTIONS;

  localparam logic [31:0] RESET_VAL_DEFAULT = 32'd1337;

endpackage

// File: rtl/testmasterslave5_rr_pick.sv
// Two-way round-robin winner select; purely combinational, zero latency.
// The requester that did not own the last grant wins a tie.
module testmasterslave5_rr_pick (
  input  logic i_sync0,
  input  logic i_sync1,
  input  logic i_grant_id,
  output logic o_any,
  output logic o_winner
);

  assign o_any    = i_sync0 | i_sync1;
  assign o_winner = (i_sync0 & i_sync1) ? ~i_grant_id : i_sync1;

endmodule

// File: rtl/testmasterslave5_arbiter.sv
// Round-robin arbiter sharing one blocking output between two requesters.
// Grant is visible one cycle after sampling; m_out is held until the sink accepts it.
module testmasterslave5_arbiter
  import testmasterslave5_types::*;
#(
  parameter logic [31:0] RESET_VAL = RESET_VAL_DEFAULT,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      req0,
  input  logic             req0_sync,
  output logic             req0_notify,
  input  logic [31:0]      req1,
  input  logic             req1_sync,
  output logic             req1_notify,
  output logic [31:0]      m_out,
  output logic             m_out_notify,
  input  logic             m_out_sync,
  output logic             grant_id,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
);

  TestMasterSlave5_arbiter_SECTIONS r_section;

  logic [31:0]      r_m_out;
  logic             r_m_out_notify;
  logic             r_req0_notify;
  logic             r_req1_notify;
  logic             r_grant_id;
  logic [CNT_W-1:0] r_gnt_cnt0;
  logic [CNT_W-1:0] r_gnt_cnt1;

  logic w_any;
  logic w_winner;

  testmasterslave5_rr_pick u_rr_pick (
    .i_sync0    (req0_sync),
    .i_sync1    (req1_sync),
    .i_grant_id (r_grant_id),
    .o_any      (w_any),
    .o_winner   (w_winner)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_section      <= section_idle;
      r_m_out        <= RESET_VAL;
      r_m_out_notify <= 1'b0;
      r_req0_notify  <= 1'b0;
      r_req1_notify  <= 1'b0;
      r_grant_id     <= 1'b1;
      r_gnt_cnt0     <= '0;
      r_gnt_cnt1     <= '0;
    end else begin
      r_req0_notify <= 1'b0;
      r_req1_notify <= 1'b0;
      case (r_section)
        section_idle: begin
          if (w_any) begin
            r_m_out        <= w_winner ? req1 : req0;
            r_m_out_notify <= 1'b1;
            r_grant_id     <= w_winner;
            r_section      <= section_send;
            if (w_winner) begin
              r_req1_notify <= 1'b1;
              if (r_gnt_cnt1 != '1) r_gnt_cnt1 <= r_gnt_cnt1 + CNT_W'(1);
            end else begin
              r_req0_notify <= 1'b1;
              if (r_gnt_cnt0 != '1) r_gnt_cnt0 <= r_gnt_cnt0 + CNT_W'(1);
            end
          end
        end
        section_send: begin
          // Requests are not sampled here; only the sink handshake matters.
          if (m_out_sync) begin
            r_m_out_notify <= 1'b0;
            r_section      <= section_idle;
          end
        end
        default: r_section <= section_idle;
      endcase
    end
  end

  assign m_out        = r_m_out;
  assign m_out_notify = r_m_out_notify;
  assign req0_notify  = r_req0_notify;
  assign req1_notify  = r_req1_notify;
  assign grant_id     = r_grant_id;
  assign gnt_cnt0     = r_gnt_cnt0;
  assign gnt_cnt1     = r_gnt_cnt1;

endmodule
